decode_ctrl: RTL and testbench
==============================

# decode_ctrl

Instruction-decode stage controller for the 5-stage RISC-V pipeline. It owns the IF/ID and ID/EX pipeline registers and decodes the held instruction into EX control bits, including the immediate-format select used by the immediate extender. It also sequences load-use stalls, branch/jump flushes and EX back-pressure. It sits between the fetch unit and the execute stage.

## Interface
- XLEN, 32, instruction/PC width
- CNT_W, 16, width of saturating performance counters
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- if_valid  in  1  fetch presents an instruction
- if_inst  in  XLEN  fetched instruction
- if_pc  in  XLEN  fetched PC
- if_ready  out  1  decode accepts from fetch this cycle
- ex_ready  in  1  EX can accept a new instruction (low while a multi-cycle op is busy)
- ex_flush  in  1  EX resolved a taken branch/jump; honoured only when ex_ready=1
- ex_valid  out  1  ID/EX register holds a real instruction
- ex_inst, ex_pc  out  XLEN  ID/EX instruction and PC
- ex_imm_sel  out  3  immediate format: I=0, S=1, B=2, U=3, J=4, NONE=5
- ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_jump, ex_alu_src  out  1 each  EX control bits
- ex_illegal  out  1  ID/EX holds an unrecognised opcode (treated as NOP)
- stall_cnt, flush_cnt  out  CNT_W  saturating event counters

## Operation
- Opcode is inst[6:2]. Supported classes: R (01100), I-comp (00100), load (00000), store (01000), branch (11000), jal (11011), jalr (11001), lui (01101), auipc (00101).
- rs1 is used by R, I-comp, load, jalr, store and branch. rs2 is used by R, store and branch. U and J use neither.
- Decode: R→NONE, reg_write. I-comp→I, alu_src, reg_write. Load→I, alu_src, mem_read, reg_write. Store→S, alu_src, mem_write. Branch→B, branch. jal→J, jump, reg_write. jalr→I, jump, alu_src, reg_write. lui/auipc→U, alu_src, reg_write.
- Any other opcode: all control bits 0, imm_sel NONE, illegal=1.
- Hazard = ex_valid & ex_mem_read & ex_inst[11:7]≠0 & id_valid & ((rs1 used & rs1==ex_rd) | (rs2 used & rs2==ex_rd)).
- FSM states: RUN, STALL, FLUSH.
  - RUN→STALL when hazard & ex_ready.
  - Any state→FLUSH when ex_flush & ex_ready.
  - STALL and FLUSH return to RUN next cycle unless re-triggered.
- Per-cycle priority, highest first:
  - ex_flush & ex_ready: ID valid cleared, ID/EX loads a bubble (valid=0, all control 0), if_ready=0, flush_cnt+1.
  - ex_ready=0: both registers hold, if_ready=0.
  - Hazard: ID holds, ID/EX loads a bubble, if_ready=0, stall_cnt+1.
  - Otherwise: ID/EX loads decoded ID contents. ID loads if_inst/if_pc with valid=if_valid. if_ready=1.
- Bubbles never cause hazards and never assert illegal.
- Counters saturate at all-ones. They do not wrap.

## Timing
- Reset (async assert, sync release): ID valid 0, ID inst/pc 0, ex_valid 0, all ex_* 0, ex_imm_sel NONE, counters 0, state RUN.
- if_ready is combinational from registered state, ex_ready and ex_flush. There is no combinational path from if_valid or if_inst to if_ready.
- Handshake: fetch transfer occurs on a cycle with if_valid & if_ready. If fetch holds if_valid while if_ready=0, it must keep if_inst/if_pc stable.
- Latency: an accepted instruction appears on ex_* 2 cycles after acceptance with no stalls. It appears 3 cycles after acceptance with one load-use stall.
- Load-use costs exactly one bubble. In the next cycle the load has left EX, so the hazard clears.
- ex_flush with ex_ready=0 is ignored, and the controller waits for EX to complete. ex_flush together with a hazard: flush wins, and stall_cnt does not increment.
- Reset asserted mid-stall or mid-flush returns to the reset values immediately.

## Structure
- Shared package `rv_pkg`: opcode constants (the nine classes above), `imm_sel_t` encoding, control-bundle struct, and a NOP/bubble constant.
- One sub-module: `rv_decode`, purely combinational, taking inst and producing the control bundle, imm_sel, illegal, rs1_used and rs2_used. It is reused by any later decoder.
- Top level holds the FSM, both pipeline registers, the hazard compare and the counters.

## Test plan
- Stream 0x00500093, 0x00A00113, 0x002081B3 with ex_ready=1 → each appears on ex_inst 2 cycles after acceptance, ex_imm_sel=0,0,5, ex_reg_write=1, no bubbles.
- Load-use: 0x0000A103 (lw x2,0(x1)) then 0x00210233 (add x4,x2,x2) → one bubble (ex_valid=0 one cycle), if_ready=0 one cycle, stall_cnt=1. Same pair with rd=x0 → no bubble.
- Flush: 0x00000463 (beq) in EX asserts ex_flush with ex_ready=1 while 0x00100093 sits in ID → next cycle ex_valid=0, ID emptied, flush_cnt=1, state FLUSH then RUN.
- Back-pressure: ex_ready=0 for 3 cycles with ID and EX full → ex_* and ID stable, if_ready=0. An ex_flush pulse during this window is ignored and flush_cnt stays 0.
- Illegal 0xFFFFFFFF → ex_illegal=1, all control bits 0, ex_imm_sel=5. Flush plus hazard in the same cycle → bubble, flush_cnt+1, stall_cnt unchanged.
- Assert rst_n low during STALL → all outputs take reset values asynchronously. Force stall_cnt to 0xFFFF and stall again → counter stays at 0xFFFF.

Source files
------------

// File: rtl/rv_pkg.sv
// ---------------------------------------------------------------------------
// rv_pkg : shared RV32 decode types, opcode classes and bubble constant  rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package rv_pkg;

  localparam logic [4:0] c_op_r      = 5'b01100;
  localparam logic [4:0] c_op_imm    = 5'b00100;
  localparam logic [4:0] c_op_load   = 5'b00000;
  localparam logic [4:0] c_op_store  = 5'b01000;
  localparam logic [4:0] c_op_branch = 5'b11000;
  localparam logic [4:0] c_op_jal    = 5'b11011;
  localparam logic [4:0] c_op_jalr   = 5'b11001;
  localparam logic [4:0] c_op_lui    = 5'b01101;
  localparam logic [4:0] c_op_auipc  = 5'b00101;

  typedef enum logic [2:0] {
    IMM_I    = 3'd0,
    IMM_S    = 3'd1,
    IMM_B    = 3'd2,
    IMM_U    = 3'd3,
    IMM_J    = 3'd4,
    IMM_NONE = 3'd5
  } imm_sel_t;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic branch;
    logic jump;
    logic alu_src;
  } ctrl_t;

  localparam ctrl_t c_ctrl_nop = '0;

endpackage

`default_nettype wire

// File: rtl/rv_decode.sv
// ---------------------------------------------------------------------------
// rv_decode : combinational opcode-class decoder to EX control bundle  rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rv_decode
  import rv_pkg::*;
(
  input  logic [31:0] i_inst,
  output ctrl_t       o_ctrl,
  output logic [2:0]  o_imm_sel,
  output logic        o_illegal,
  output logic        o_rs1_used,
  output logic        o_rs2_used
);

  // Only the opcode class matters here; the rest of the word is decoded downstream.
  logic w_unused_bits;
  assign w_unused_bits = ^{i_inst[31:7], i_inst[1:0]};

  always_comb begin
    o_ctrl     = c_ctrl_nop;
    o_imm_sel  = IMM_NONE;
    o_illegal  = 1'b0;
    o_rs1_used = 1'b0;
    o_rs2_used = 1'b0;
    case (i_inst[6:2])
      c_op_r: begin
        o_ctrl.reg_write = 1'b1;
        o_rs1_used       = 1'b1;
        o_rs2_used       = 1'b1;
      end
      c_op_imm: begin
        o_imm_sel        = IMM_I;
        o_ctrl.alu_src   = 1'b1;
        o_ctrl.reg_write = 1'b1;
        o_rs1_used       = 1'b1;
      end
      c_op_load: begin
        o_imm_sel        = IMM_I;
        o_ctrl.alu_src   = 1'b1;
        o_ctrl.mem_read  = 1'b1;
        o_ctrl.reg_write = 1'b1;
        o_rs1_used       = 1'b1;
      end
      c_op_store: begin
        o_imm_sel        = IMM_S;
        o_ctrl.alu_src   = 1'b1;
        o_ctrl.mem_write = 1'b1;
        o_rs1_used       = 1'b1;
        o_rs2_used       = 1'b1;
      end
      c_op_branch: begin
        o_imm_sel     = IMM_B;
        o_ctrl.branch = 1'b1;
        o_rs1_used    = 1'b1;
        o_rs2_used    = 1'b1;
      end
      c_op_jal: begin
        o_imm_sel        = IMM_J;
        o_ctrl.jump      = 1'b1;
        o_ctrl.reg_write = 1'b1;
      end
      c_op_jalr: begin
        o_imm_sel        = IMM_I;
        o_ctrl.jump      = 1'b1;
        o_ctrl.alu_src   = 1'b1;
        o_ctrl.reg_write = 1'b1;
        o_rs1_used       = 1'b1;
      end
      c_op_lui, c_op_auipc: begin
        o_imm_sel        = IMM_U;
        o_ctrl.alu_src   = 1'b1;
        o_ctrl.reg_write = 1'b1;
      end
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/decode_ctrl.sv
// ---------------------------------------------------------------------------
// decode_ctrl : ID stage - IF/ID + ID/EX registers, load-use/flush/backpressure  rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module decode_ctrl
  import rv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             if_valid,
  input  logic [XLEN-1:0]  if_inst,
  input  logic [XLEN-1:0]  if_pc,
  output logic             if_ready,
  input  logic             ex_ready,
  input  logic             ex_flush,
  output logic             ex_valid,
  output logic [XLEN-1:0]  ex_inst,
  output logic [XLEN-1:0]  ex_pc,
  output logic [2:0]       ex_imm_sel,
  output logic             ex_reg_write,
  output logic             ex_mem_read,
  output logic             ex_mem_write,
  output logic             ex_branch,
  output logic             ex_jump,
  output logic             ex_alu_src,
  output logic             ex_illegal,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [1:0] c_st_run   = 2'd0;
  localparam logic [1:0] c_st_stall = 2'd1;
  localparam logic [1:0] c_st_flush = 2'd2;

  logic [1:0]      r_state;
  logic [1:0]      w_state_nxt;

  logic            r_id_valid;
  logic [XLEN-1:0] r_id_inst;
  logic [XLEN-1:0] r_id_pc;

  logic            r_ex_valid;
  logic [XLEN-1:0] r_ex_inst;
  logic [XLEN-1:0] r_ex_pc;
  ctrl_t           r_ex_ctrl;
  logic [2:0]      r_ex_imm_sel;
  logic            r_ex_illegal;

  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  ctrl_t           w_ctrl;
  logic [2:0]      w_imm_sel;
  logic            w_illegal;
  logic            w_rs1_used;
  logic            w_rs2_used;
  logic            w_hazard;
  logic            w_do_flush;
  logic            w_do_stall;
  logic            w_advance;
  logic            w_load_real;
  logic [4:0]      w_ex_rd;

  rv_decode u_decode (
    .i_inst     (r_id_inst[31:0]),
    .o_ctrl     (w_ctrl),
    .o_imm_sel  (w_imm_sel),
    .o_illegal  (w_illegal),
    .o_rs1_used (w_rs1_used),
    .o_rs2_used (w_rs2_used)
  );

  // Bubbles carry mem_read=0, so they can never raise a load-use hazard.
  assign w_ex_rd  = r_ex_inst[11:7];
  assign w_hazard = r_ex_valid & r_ex_ctrl.mem_read & (w_ex_rd != 5'd0) & r_id_valid &
                    ((w_rs1_used & (r_id_inst[19:15] == w_ex_rd)) |
                     (w_rs2_used & (r_id_inst[24:20] == w_ex_rd)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= c_st_run;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = c_st_run;
    case (r_state)
      c_st_run, c_st_stall, c_st_flush:
        if (ex_ready && w_hazard) w_state_nxt = c_st_stall;
      default: w_state_nxt = c_st_run;
    endcase
    if (ex_ready && ex_flush) w_state_nxt = c_st_flush;
  end

  // Flush outranks stall; with ex_ready low everything holds and flush is ignored.
  always_comb begin
    w_do_flush = ex_ready & ex_flush;
    w_do_stall = ex_ready & ~ex_flush & w_hazard;
    w_advance  = ex_ready & ~ex_flush & ~w_hazard;
    if_ready   = w_advance;
  end

  assign w_load_real = w_advance & r_id_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_id_valid   <= 1'b0;
      r_id_inst    <= '0;
      r_id_pc      <= '0;
      r_ex_valid   <= 1'b0;
      r_ex_inst    <= '0;
      r_ex_pc      <= '0;
      r_ex_ctrl    <= c_ctrl_nop;
      r_ex_imm_sel <= IMM_NONE;
      r_ex_illegal <= 1'b0;
    end else if (ex_ready) begin
      r_ex_valid   <= w_load_real;
      r_ex_inst    <= w_load_real ? r_id_inst : '0;
      r_ex_pc      <= w_load_real ? r_id_pc : '0;
      r_ex_ctrl    <= w_load_real ? w_ctrl : c_ctrl_nop;
      r_ex_imm_sel <= w_load_real ? w_imm_sel : IMM_NONE;
      r_ex_illegal <= w_load_real & w_illegal;
      if (w_advance) begin
        r_id_valid <= if_valid;
        r_id_inst  <= if_inst;
        r_id_pc    <= if_pc;
      end else if (w_do_flush) begin
        r_id_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_do_stall && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_do_flush && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign ex_valid     = r_ex_valid;
  assign ex_inst      = r_ex_inst;
  assign ex_pc        = r_ex_pc;
  assign ex_imm_sel   = r_ex_imm_sel;
  assign ex_reg_write = r_ex_ctrl.reg_write;
  assign ex_mem_read  = r_ex_ctrl.mem_read;
  assign ex_mem_write = r_ex_ctrl.mem_write;
  assign ex_branch    = r_ex_ctrl.branch;
  assign ex_jump      = r_ex_ctrl.jump;
  assign ex_alu_src   = r_ex_ctrl.alu_src;
  assign ex_illegal   = r_ex_illegal;
  assign stall_cnt    = r_stall_cnt;
  assign flush_cnt    = r_flush_cnt;

endmodule

`default_nettype wire

// File: tb/tb_decode_ctrl.sv
// ---------------------------------------------------------------------------
// tb_decode_ctrl : directed scenarios plus randomized run against a pipeline model  rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_decode_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic        if_ready;
  logic        ex_ready;
  logic        ex_flush;
  logic        ex_valid;
  logic [31:0] ex_inst;
  logic [31:0] ex_pc;
  logic [2:0]  ex_imm_sel;
  logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_jump, ex_alu_src;
  logic        ex_illegal;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;

  // Narrow-counter twin, fed identically, to reach saturation in a few events.
  logic        s_if_ready, s_ex_valid, s_rw, s_mr, s_mw, s_br, s_jp, s_as, s_ill;
  logic [31:0] s_ex_inst, s_ex_pc;
  logic [2:0]  s_imm;
  logic [1:0]  stall_cnt_s, flush_cnt_s;

  always #5 clk = ~clk;

  decode_ctrl #(.XLEN(32), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc),
    .if_ready(if_ready), .ex_ready(ex_ready), .ex_flush(ex_flush), .ex_valid(ex_valid),
    .ex_inst(ex_inst), .ex_pc(ex_pc), .ex_imm_sel(ex_imm_sel), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_branch(ex_branch),
    .ex_jump(ex_jump), .ex_alu_src(ex_alu_src), .ex_illegal(ex_illegal),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  decode_ctrl #(.XLEN(32), .CNT_W(2)) dut_s (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc),
    .if_ready(s_if_ready), .ex_ready(ex_ready), .ex_flush(ex_flush), .ex_valid(s_ex_valid),
    .ex_inst(s_ex_inst), .ex_pc(s_ex_pc), .ex_imm_sel(s_imm), .ex_reg_write(s_rw),
    .ex_mem_read(s_mr), .ex_mem_write(s_mw), .ex_branch(s_br),
    .ex_jump(s_jp), .ex_alu_src(s_as), .ex_illegal(s_ill),
    .stall_cnt(stall_cnt_s), .flush_cnt(flush_cnt_s)
  );

  // {valid, imm_sel, reg_write, mem_read, mem_write, branch, jump, alu_src, illegal}
  logic [10:0] w_ex_bus;
  assign w_ex_bus = {ex_valid, ex_imm_sel, ex_reg_write, ex_mem_read, ex_mem_write,
                     ex_branch, ex_jump, ex_alu_src, ex_illegal};

  int total = 0;
  int bad   = 0;

  // Reference pipeline: two slots plus event counts.
  bit          m_id_v, m_ex_v;
  logic [31:0] m_id_inst, m_id_pc, m_ex_inst, m_ex_pc;
  int          m_stall, m_flush;

  typedef struct packed {
    logic [2:0] imm;
    logic [5:0] c;   // reg_write, mem_read, mem_write, branch, jump, alu_src
    logic       ill;
    logic       r1;
    logic       r2;
  } dec_t;

  function automatic dec_t ref_dec(logic [31:0] i);
    case (i[6:2])
      5'b01100:          return '{3'd5, 6'b100000, 1'b0, 1'b1, 1'b1};
      5'b00100:          return '{3'd0, 6'b100001, 1'b0, 1'b1, 1'b0};
      5'b00000:          return '{3'd0, 6'b110001, 1'b0, 1'b1, 1'b0};
      5'b01000:          return '{3'd1, 6'b001001, 1'b0, 1'b1, 1'b1};
      5'b11000:          return '{3'd2, 6'b000100, 1'b0, 1'b1, 1'b1};
      5'b11011:          return '{3'd4, 6'b100010, 1'b0, 1'b0, 1'b0};
      5'b11001:          return '{3'd0, 6'b100011, 1'b0, 1'b1, 1'b0};
      5'b01101, 5'b00101: return '{3'd3, 6'b100001, 1'b0, 1'b0, 1'b0};
      default:           return '{3'd5, 6'b000000, 1'b1, 1'b0, 1'b0};
    endcase
  endfunction

  function automatic bit ref_hazard();
    dec_t       e  = ref_dec(m_ex_inst);
    dec_t       d  = ref_dec(m_id_inst);
    logic [4:0] rd = m_ex_inst[11:7];
    return m_ex_v && e.c[4] && (rd != 5'd0) && m_id_v &&
           ((d.r1 && (m_id_inst[19:15] == rd)) || (d.r2 && (m_id_inst[24:20] == rd)));
  endfunction

  function automatic bit ref_if_ready();
    return ex_ready && !ex_flush && !ref_hazard();
  endfunction

  function automatic logic [10:0] ref_ex_bus();
    dec_t d = ref_dec(m_ex_inst);
    if (!m_ex_v) return {1'b0, 3'd5, 6'b0, 1'b0};
    return {1'b1, d.imm, d.c, d.ill};
  endfunction

  function automatic int sat2(int v);
    return (v > 3) ? 3 : v;
  endfunction

  task automatic m_clear();
    m_id_v = 0; m_ex_v = 0;
    m_id_inst = '0; m_id_pc = '0; m_ex_inst = '0; m_ex_pc = '0;
    m_stall = 0; m_flush = 0;
  endtask

  task automatic put(logic [31:0] inst, logic [31:0] pc, bit v);
    if_inst = inst; if_pc = pc; if_valid = v;
  endtask

  // One clock: model advances on the edge, returns on the following falling edge.
  task automatic tick();
    bit fl, hz;
    fl = ex_ready && ex_flush;
    hz = ref_hazard();
    @(posedge clk);
    if (fl) begin
      m_id_v = 0; m_ex_v = 0;
      if (m_flush < 65535) m_flush++;
    end else if (ex_ready) begin
      if (hz) begin
        m_ex_v = 0;
        if (m_stall < 65535) m_stall++;
      end else begin
        m_ex_v = m_id_v; m_ex_inst = m_id_inst; m_ex_pc = m_id_pc;
        m_id_v = if_valid; m_id_inst = if_inst; m_id_pc = if_pc;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; ex_ready = 1'b0; ex_flush = 1'b0;
    put(32'h0, 32'h0, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_clear();
  endtask

  localparam logic [31:0] I_ADDI1 = 32'h00500093;
  localparam logic [31:0] I_ADDI2 = 32'h00A00113;
  localparam logic [31:0] I_ADD3  = 32'h002081B3;
  localparam logic [31:0] I_LW    = 32'h0000A103;
  localparam logic [31:0] I_ADDU  = 32'h00210233;
  localparam logic [31:0] I_LW0   = 32'h0000A003;
  localparam logic [31:0] I_ADD0  = 32'h00000233;
  localparam logic [31:0] I_BEQ   = 32'h00000463;
  localparam logic [31:0] I_ADDIX = 32'h00100093;

  task automatic test_reset();
    rst_n = 1'b0; ex_ready = 1'b0; ex_flush = 1'b0;
    put(32'h0, 32'h0, 1'b0);
    repeat (2) @(negedge clk);
    total++;
    if (w_ex_bus !== {1'b0, 3'd5, 7'b0} || ex_inst !== 32'h0 || ex_pc !== 32'h0 || if_ready !== 1'b0) begin
      bad++; $display("FAIL reset_outputs bus=%b inst=%h pc=%h if_ready=%b exp bus=%b", w_ex_bus, ex_inst, ex_pc, if_ready, {1'b0, 3'd5, 7'b0});
    end
    total++;
    if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
      bad++; $display("FAIL reset_counters stall=%0d flush=%0d exp 0/0", stall_cnt, flush_cnt);
    end
    rst_n = 1'b1;
    m_clear();
  endtask

  task automatic test_stream();
    do_reset(); ex_ready = 1'b1;
    put(I_ADDI1, 32'h100, 1'b1); #1;
    total++;
    if (if_ready !== 1'b1) begin bad++; $display("FAIL stream_if_ready got=%b exp=1", if_ready); end
    tick();
    put(I_ADDI2, 32'h104, 1'b1); tick();
    total++;
    if (w_ex_bus !== {1'b1, 3'd0, 6'b100001, 1'b0} || ex_inst !== I_ADDI1 || ex_pc !== 32'h100) begin
      bad++; $display("FAIL stream_inst0 bus=%b inst=%h pc=%h exp inst=%h", w_ex_bus, ex_inst, ex_pc, I_ADDI1);
    end
    put(I_ADD3, 32'h108, 1'b1); tick();
    total++;
    if (w_ex_bus !== {1'b1, 3'd0, 6'b100001, 1'b0} || ex_inst !== I_ADDI2 || ex_pc !== 32'h104) begin
      bad++; $display("FAIL stream_inst1 bus=%b inst=%h pc=%h exp inst=%h", w_ex_bus, ex_inst, ex_pc, I_ADDI2);
    end
    put(32'h0, 32'h0, 1'b0); tick();
    total++;
    if (w_ex_bus !== {1'b1, 3'd5, 6'b100000, 1'b0} || ex_inst !== I_ADD3 || stall_cnt !== 16'd0) begin
      bad++; $display("FAIL stream_inst2 bus=%b inst=%h stall=%0d exp inst=%h", w_ex_bus, ex_inst, stall_cnt, I_ADD3);
    end
  endtask

  task automatic test_load_use();
    do_reset(); ex_ready = 1'b1;
    put(I_LW, 32'h0, 1'b1); tick();
    put(I_ADDU, 32'h4, 1'b1); tick();
    total++;
    if (w_ex_bus !== {1'b1, 3'd0, 6'b110001, 1'b0} || ex_inst !== I_LW) begin
      bad++; $display("FAIL loaduse_lw_in_ex bus=%b inst=%h exp inst=%h", w_ex_bus, ex_inst, I_LW);
    end
    put(32'h0, 32'h0, 1'b0); #1;
    total++;
    if (if_ready !== 1'b0) begin bad++; $display("FAIL loaduse_if_ready_low got=%b exp=0", if_ready); end
    tick();
    total++;
    if (ex_valid !== 1'b0 || stall_cnt !== 16'd1) begin
      bad++; $display("FAIL loaduse_bubble ex_valid=%b stall=%0d exp 0/1", ex_valid, stall_cnt);
    end
    #1;
    total++;
    if (if_ready !== 1'b1) begin bad++; $display("FAIL loaduse_if_ready_back got=%b exp=1", if_ready); end
    tick();
    total++;
    if (ex_valid !== 1'b1 || ex_inst !== I_ADDU || ex_pc !== 32'h4) begin
      bad++; $display("FAIL loaduse_add_in_ex valid=%b inst=%h pc=%h exp inst=%h", ex_valid, ex_inst, ex_pc, I_ADDU);
    end

    do_reset(); ex_ready = 1'b1;
    put(I_LW0, 32'h0, 1'b1); tick();
    put(I_ADD0, 32'h4, 1'b1); tick();
    put(32'h0, 32'h0, 1'b0); #1;
    total++;
    if (if_ready !== 1'b1) begin bad++; $display("FAIL loaduse_x0_if_ready got=%b exp=1", if_ready); end
    tick();
    total++;
    if (ex_valid !== 1'b1 || ex_inst !== I_ADD0 || stall_cnt !== 16'd0) begin
      bad++; $display("FAIL loaduse_x0_nobubble valid=%b inst=%h stall=%0d exp 1/%h/0", ex_valid, ex_inst, stall_cnt, I_ADD0);
    end
  endtask

  task automatic test_flush();
    do_reset(); ex_ready = 1'b1;
    put(I_BEQ, 32'h200, 1'b1); tick();
    put(I_ADDIX, 32'h204, 1'b1); tick();
    total++;
    if (w_ex_bus !== {1'b1, 3'd2, 6'b000100, 1'b0}) begin
      bad++; $display("FAIL flush_beq_decode bus=%b exp=%b", w_ex_bus, {1'b1, 3'd2, 6'b000100, 1'b0});
    end
    put(I_ADDI1, 32'h208, 1'b1); ex_flush = 1'b1; #1;
    total++;
    if (if_ready !== 1'b0) begin bad++; $display("FAIL flush_if_ready got=%b exp=0", if_ready); end
    tick(); ex_flush = 1'b0;
    total++;
    if (ex_valid !== 1'b0 || flush_cnt !== 16'd1 || stall_cnt !== 16'd0) begin
      bad++; $display("FAIL flush_bubble valid=%b flush=%0d stall=%0d exp 0/1/0", ex_valid, flush_cnt, stall_cnt);
    end
    tick();
    total++;
    if (ex_valid !== 1'b0) begin bad++; $display("FAIL flush_id_emptied ex_valid=%b exp=0", ex_valid); end
    put(32'h0, 32'h0, 1'b0); tick();
    total++;
    if (ex_valid !== 1'b1 || ex_inst !== I_ADDI1 || ex_pc !== 32'h208) begin
      bad++; $display("FAIL flush_resume valid=%b inst=%h pc=%h exp inst=%h", ex_valid, ex_inst, ex_pc, I_ADDI1);
    end
  endtask

  task automatic test_backpressure();
    do_reset(); ex_ready = 1'b1;
    put(I_ADDI1, 32'h300, 1'b1); tick();
    put(I_ADDI2, 32'h304, 1'b1); tick();
    put(I_ADD3, 32'h308, 1'b1); ex_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      ex_flush = (k == 1); #1;
      total++;
      if (if_ready !== 1'b0) begin bad++; $display("FAIL bp_if_ready cyc=%0d got=%b exp=0", k, if_ready); end
      tick();
      total++;
      if (ex_valid !== 1'b1 || ex_inst !== I_ADDI1 || ex_pc !== 32'h300 || flush_cnt !== 16'd0) begin
        bad++; $display("FAIL bp_hold cyc=%0d valid=%b inst=%h flush=%0d exp 1/%h/0", k, ex_valid, ex_inst, flush_cnt, I_ADDI1);
      end
    end
    ex_flush = 1'b0; ex_ready = 1'b1; tick();
    total++;
    if (ex_inst !== I_ADDI2 || ex_pc !== 32'h304) begin
      bad++; $display("FAIL bp_release inst=%h pc=%h exp %h/304", ex_inst, ex_pc, I_ADDI2);
    end
    put(32'h0, 32'h0, 1'b0); tick();
    total++;
    if (ex_valid !== 1'b1 || ex_inst !== I_ADD3) begin
      bad++; $display("FAIL bp_next valid=%b inst=%h exp 1/%h", ex_valid, ex_inst, I_ADD3);
    end
  endtask

  task automatic test_illegal();
    do_reset(); ex_ready = 1'b1;
    put(32'hFFFF_FFFF, 32'h400, 1'b1); tick();
    put(32'h0, 32'h0, 1'b0); tick();
    total++;
    if (w_ex_bus !== {1'b1, 3'd5, 6'b000000, 1'b1}) begin
      bad++; $display("FAIL illegal_decode bus=%b exp=%b", w_ex_bus, {1'b1, 3'd5, 6'b000000, 1'b1});
    end
    tick();
    total++;
    if (ex_illegal !== 1'b0 || ex_valid !== 1'b0) begin
      bad++; $display("FAIL illegal_bubble_clean ill=%b valid=%b exp 0/0", ex_illegal, ex_valid);
    end

    do_reset(); ex_ready = 1'b1;
    put(I_LW, 32'h0, 1'b1); tick();
    put(I_ADDU, 32'h4, 1'b1); tick();
    put(32'h0, 32'h0, 1'b0); ex_flush = 1'b1; tick(); ex_flush = 1'b0;
    total++;
    if (ex_valid !== 1'b0 || flush_cnt !== 16'd1 || stall_cnt !== 16'd0) begin
      bad++; $display("FAIL flush_over_hazard valid=%b flush=%0d stall=%0d exp 0/1/0", ex_valid, flush_cnt, stall_cnt);
    end
    tick();
    total++;
    if (ex_valid !== 1'b0) begin bad++; $display("FAIL flush_over_hazard_drop valid=%b exp=0", ex_valid); end
  endtask

  task automatic test_reset_mid_stall();
    do_reset(); ex_ready = 1'b1;
    put(I_LW, 32'h0, 1'b1); tick();
    put(I_ADDU, 32'h4, 1'b1); tick();
    put(32'h0, 32'h0, 1'b0); tick();
    total++;
    if (stall_cnt !== 16'd1) begin bad++; $display("FAIL rst_stall_pre stall=%0d exp=1", stall_cnt); end
    #1 rst_n = 1'b0;
    #1;
    total++;
    if (stall_cnt !== 16'd0 || w_ex_bus !== {1'b0, 3'd5, 7'b0} || ex_inst !== 32'h0 || if_ready !== 1'b1) begin
      bad++; $display("FAIL rst_async stall=%0d bus=%b inst=%h if_ready=%b exp 0/%b/0/1", stall_cnt, w_ex_bus, ex_inst, if_ready, {1'b0, 3'd5, 7'b0});
    end
    @(negedge clk);
    rst_n = 1'b1;
    m_clear();
    tick();
    total++;
    if (ex_valid !== 1'b0 || stall_cnt !== 16'd0) begin
      bad++; $display("FAIL rst_id_cleared valid=%b stall=%0d exp 0/0", ex_valid, stall_cnt);
    end
  endtask

  task automatic test_saturation();
    do_reset(); ex_ready = 1'b1;
    for (int n = 0; n < 5; n++) begin
      put(I_LW, 32'h0, 1'b1); tick();
      put(I_ADDU, 32'h4, 1'b1); tick();
      put(32'h0, 32'h0, 1'b0); tick(); tick(); tick();
    end
    for (int n = 0; n < 4; n++) begin
      ex_flush = 1'b1; tick(); ex_flush = 1'b0; tick();
    end
    total++;
    if (stall_cnt !== 16'd5 || flush_cnt !== 16'd4) begin
      bad++; $display("FAIL sat_wide stall=%0d flush=%0d exp 5/4", stall_cnt, flush_cnt);
    end
    total++;
    if (stall_cnt_s !== 2'd3 || flush_cnt_s !== 2'd3) begin
      bad++; $display("FAIL sat_narrow stall=%0d flush=%0d exp 3/3", stall_cnt_s, flush_cnt_s);
    end
  endtask

  function automatic logic [31:0] rnd_inst();
    logic [4:0] ops [11];
    logic [4:0] op;
    ops = '{5'b01100, 5'b00100, 5'b00000, 5'b00000, 5'b01000, 5'b11000,
            5'b11011, 5'b11001, 5'b01101, 5'b00101, 5'b11111};
    op = ops[$urandom_range(0, 10)];
    return {7'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            3'($urandom), 5'($urandom_range(0, 3)), op, 2'b11};
  endfunction

  task automatic test_random();
    bit acc;
    do_reset();
    put(rnd_inst(), 32'($urandom), 1'b1);
    for (int c = 0; c < 800; c++) begin
      ex_ready = ($urandom_range(0, 9) < 8);
      ex_flush = ($urandom_range(0, 9) == 0);
      #1;
      total++;
      if (if_ready !== ref_if_ready()) begin
        bad++; $display("FAIL rnd_if_ready cyc=%0d got=%b exp=%b", c, if_ready, ref_if_ready());
      end
      acc = if_valid && if_ready;
      tick();
      total++;
      if (w_ex_bus !== ref_ex_bus() || (m_ex_v && (ex_inst !== m_ex_inst || ex_pc !== m_ex_pc))) begin
        bad++; $display("FAIL rnd_ex cyc=%0d bus=%b inst=%h pc=%h exp bus=%b inst=%h pc=%h", c, w_ex_bus, ex_inst, ex_pc, ref_ex_bus(), m_ex_inst, m_ex_pc);
      end
      total++;
      if (stall_cnt !== 16'(m_stall) || flush_cnt !== 16'(m_flush) ||
          stall_cnt_s !== 2'(sat2(m_stall)) || flush_cnt_s !== 2'(sat2(m_flush))) begin
        bad++; $display("FAIL rnd_cnt cyc=%0d stall=%0d/%0d flush=%0d/%0d exp %0d/%0d", c, stall_cnt, stall_cnt_s, flush_cnt, flush_cnt_s, m_stall, m_flush);
      end
      if (acc || !if_valid) put(rnd_inst(), 32'($urandom), ($urandom_range(0, 4) != 0));
    end
  endtask

  initial begin
    m_clear();
    test_reset();
    test_stream();
    test_load_use();
    test_flush();
    test_backpressure();
    test_illegal();
    test_reset_mid_stall();
    test_saturation();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
